// File: rtl/counter_cmd_ctrl.sv
// Button command front end for an up/down counter: synchronize, debounce, edge-detect, then
// arbitrate into registered en/up/load/sys_clr pulses. Auto-repeat under COUNTER_CMD_AUTO_REPEAT_EN.
module counter_cmd_ctrl #(
    parameter int N          = 4,
    parameter int DB_CYCLES  = 16,
    parameter int RPT_DELAY  = 64,
    parameter int RPT_PERIOD = 16,
    parameter int SATURATE   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         btn_up,
    input  logic         btn_dn,
    input  logic         btn_ld,
    input  logic         btn_clr,
    input  logic [N-1:0] d_in,
    input  logic         max_value_tick,
    input  logic         min_value_tick,
    output logic         en,
    output logic         up,
    output logic         load,
    output logic         sys_clr,
    output logic [N-1:0] d
);
    localparam int NB   = 4;
    localparam int B_UP = 0;
    localparam int B_DN = 1;
    localparam int B_LD = 2;
    localparam int B_CL = 3;
    localparam int DB_W = $clog2(DB_CYCLES + 1);

    generate
        if (N < 1 || DB_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_cfg
            $error("counter_cmd_ctrl: N, DB_CYCLES, RPT_DELAY and RPT_PERIOD must all be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, STEP, HOLD, RELEASE} state_t;

    logic [NB-1:0] btn_raw;
    logic [NB-1:0] sync1_reg, sync2_reg;
    logic [NB-1:0] db_level;
    logic [NB-1:0] db_prev_reg;
    logic [NB-1:0] rise;
    state_t        state_reg;
    logic          dir_up_reg;
    logic          up_ok, dn_ok, held, step_ok;

    assign btn_raw = {btn_clr, btn_ld, btn_dn, btn_up};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Any sample that agrees with the accepted level restarts the stability count.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_db
            logic [DB_W-1:0] cnt_reg;
            logic            level_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else if (sync2_reg[gi] == level_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg >= DB_W'(DB_CYCLES - 1)) begin
                    cnt_reg   <= '0;
                    level_reg <= sync2_reg[gi];
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
            assign db_level[gi] = level_reg;
        end
    endgenerate

    assign rise    = db_level & ~db_prev_reg;
    assign up_ok   = (SATURATE == 0) || !max_value_tick;
    assign dn_ok   = (SATURATE == 0) || !min_value_tick;
    assign held    = dir_up_reg ? db_level[B_UP] : db_level[B_DN];
    assign step_ok = dir_up_reg ? up_ok : dn_ok;

`ifdef COUNTER_CMD_AUTO_REPEAT_EN
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    logic [RPT_W-1:0] rpt_cnt_reg;
    logic             rpt_first_reg;
    logic [RPT_W-1:0] rpt_target;
    // rpt_cnt_reg holds cycles elapsed since the last issued (or suppressed) step.
    assign rpt_target = rpt_first_reg ? RPT_W'(RPT_DELAY - 1) : RPT_W'(RPT_PERIOD - 1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            db_prev_reg   <= '0;
            dir_up_reg    <= 1'b1;
            en            <= 1'b0;
            up            <= 1'b1;
            load          <= 1'b0;
            sys_clr       <= 1'b0;
            d             <= '0;
`ifdef COUNTER_CMD_AUTO_REPEAT_EN
            rpt_cnt_reg   <= '0;
            rpt_first_reg <= 1'b0;
`endif
        end else begin
            db_prev_reg <= db_level;
            en          <= 1'b0;
            load        <= 1'b0;
            sys_clr     <= 1'b0;
            if (rise[B_CL]) begin
                sys_clr   <= 1'b1;
                state_reg <= RELEASE;
            end else if (rise[B_LD]) begin
                load      <= 1'b1;
                d         <= d_in;
                state_reg <= RELEASE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (rise[B_UP] ^ rise[B_DN]) begin
                            dir_up_reg <= rise[B_UP];
                            state_reg  <= STEP;
                            if (rise[B_UP] ? up_ok : dn_ok) begin
                                en <= 1'b1;
                                up <= rise[B_UP];
                            end
                        end else if (rise[B_UP] && rise[B_DN]) begin
                            state_reg <= RELEASE;
                        end
                    end
                    STEP: begin
                        state_reg <= held ? HOLD : RELEASE;
`ifdef COUNTER_CMD_AUTO_REPEAT_EN
                        rpt_cnt_reg   <= RPT_W'(1);
                        rpt_first_reg <= 1'b1;
`endif
                    end
                    HOLD: begin
                        if (!held) begin
                            state_reg <= IDLE;
`ifdef COUNTER_CMD_AUTO_REPEAT_EN
                        end else if (rpt_cnt_reg >= rpt_target) begin
                            rpt_cnt_reg   <= '0;
                            rpt_first_reg <= 1'b0;
                            if (step_ok) begin
                                en <= 1'b1;
                                up <= dir_up_reg;
                            end
                        end else begin
                            rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
`endif
                        end
                    end
                    RELEASE: begin
                        if (db_level == '0) state_reg <= IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Scoreboard bench for counter_cmd_ctrl (DB_CYCLES=4); auto-repeat expectations follow
// COUNTER_CMD_AUTO_REPEAT_EN. Instance a saturates, instance b wraps.
module tb_counter_cmd_ctrl;
    localparam int LAT  = 7;  // DB_CYCLES + 3
    localparam int K_EN = 0;
    localparam int K_LD = 1;
    localparam int K_CL = 2;

    typedef struct {
        int         cyc;
        int         kind;
        logic       up;
        logic [3:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up = 1'b0, btn_dn = 1'b0, btn_ld = 1'b0, btn_clr = 1'b0;
    logic [3:0] d_in = 4'h0;
    logic       max_value_tick = 1'b0, min_value_tick = 1'b0;
    logic       en_a, up_a, load_a, clr_a;
    logic [3:0] d_a;
    logic       en_b, up_b, load_b, clr_b;
    logic [3:0] d_b;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    counter_cmd_ctrl #(.N(4), .DB_CYCLES(4), .RPT_DELAY(8), .RPT_PERIOD(4), .SATURATE(1)) dut_a (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn), .btn_ld(btn_ld),
        .btn_clr(btn_clr), .d_in(d_in), .max_value_tick(max_value_tick),
        .min_value_tick(min_value_tick), .en(en_a), .up(up_a), .load(load_a),
        .sys_clr(clr_a), .d(d_a));

    counter_cmd_ctrl #(.N(4), .DB_CYCLES(4), .RPT_DELAY(8), .RPT_PERIOD(4), .SATURATE(0)) dut_b (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn), .btn_ld(btn_ld),
        .btn_clr(btn_clr), .d_in(d_in), .max_value_tick(max_value_tick),
        .min_value_tick(min_value_tick), .en(en_b), .up(up_b), .load(load_b),
        .sys_clr(clr_b), .d(d_b));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [3:0] v);
        {btn_clr, btn_ld, btn_dn, btn_up} = v;
    endtask

    task automatic push_exp(input int at, input int kind, input logic u, input logic [3:0] dv);
        exp_t e;
        e.cyc = at; e.kind = kind; e.up = u; e.d = dv;
        exp_q.push_back(e);
    endtask

    // Watches instance a: every pulse must match the head of the expected queue.
    task automatic monitor();
        exp_t e;
        int   got;
        forever begin
            @(negedge clk);
            if (!reset) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    checks++; errors++;
                    $display("FAIL missing_pulse: nothing seen, required kind=%0d at cycle %0d", e.kind, e.cyc);
                end
                if (en_a || load_a || clr_a) begin
                    checks++;
                    got = en_a ? K_EN : (load_a ? K_LD : K_CL);
                    if (exp_q.size() == 0 || exp_q[0].cyc > cyc) begin
                        errors++;
                        $display("FAIL unexpected_pulse: en/ld/clr=%b up=%b d=%h at cycle %0d, required none",
                                 {en_a, load_a, clr_a}, up_a, d_a, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (got != e.kind || (int'(en_a) + int'(load_a) + int'(clr_a)) != 1 ||
                            (e.kind == K_EN && up_a !== e.up) || (e.kind == K_LD && d_a !== e.d)) begin
                            errors++;
                            $display("FAIL pulse_fields: cycle %0d en/ld/clr=%b up=%b d=%h, required kind=%0d up=%b d=%h",
                                     cyc, {en_a, load_a, clr_a}, up_a, d_a, e.kind, e.up, e.d);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        tick(2);
        checks += 5;
        if ({en_a, load_a, clr_a} !== 3'b000 || {en_b, load_b, clr_b} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: a=%b b=%b, required 000/000", {en_a, load_a, clr_a}, {en_b, load_b, clr_b});
        end
        if (up_a !== 1'b1) begin errors++; $display("FAIL reset_up_a: got %b, required 1", up_a); end
        if (up_b !== 1'b1) begin errors++; $display("FAIL reset_up_b: got %b, required 1", up_b); end
        if (d_a !== 4'h0) begin errors++; $display("FAIL reset_d_a: got %h, required 0", d_a); end
        if (d_b !== 4'h0) begin errors++; $display("FAIL reset_d_b: got %h, required 0", d_b); end
        reset = 1'b0;
        tick(3);
    endtask

    task automatic test_bounce();
        for (int p = 0; p < 10; p++) begin
            btn_up = (p % 2 == 0);
            tick(2);
        end
        tick(1);
        btn_up = 1'b1;
        push_exp(cyc + LAT, K_EN, 1'b1, 4'h0);
        tick(8);
        btn_up = 1'b0;
        tick(20);
    endtask

    task automatic test_priority();
        d_in = 4'hA;
        set_btns(4'b1100);
        push_exp(cyc + LAT, K_CL, 1'b0, 4'h0);
        tick(12);
        btn_up = 1'b1;                 // must be ignored while clr/ld are still held
        tick(8);
        set_btns(4'b0000);
        tick(20);
        btn_ld = 1'b1;
        push_exp(cyc + LAT, K_LD, 1'b0, 4'hA);
        tick(8);
        btn_ld = 1'b0;
        tick(20);
    endtask

    task automatic test_saturation();
        int na, nb;
        max_value_tick = 1'b1;
        btn_up = 1'b1;
        na = 0; nb = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 8) btn_up = 1'b0;
            if (en_a) na++;
            if (en_b && up_b) nb++;
        end
        checks += 2;
        if (na != 0) begin errors++; $display("FAIL sat_up_a: got %0d en pulses, required 0", na); end
        if (nb != 1) begin errors++; $display("FAIL wrap_up_b: got %0d en pulses, required 1", nb); end
        max_value_tick = 1'b0;
        min_value_tick = 1'b1;
        tick(1);
        btn_dn = 1'b1;
        na = 0; nb = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 8) btn_dn = 1'b0;
            if (en_a) na++;
            if (en_b && !up_b) nb++;
        end
        checks += 2;
        if (na != 0) begin errors++; $display("FAIL sat_dn_a: got %0d en pulses, required 0", na); end
        if (nb != 1) begin errors++; $display("FAIL wrap_dn_b: got %0d en pulses, required 1", nb); end
        min_value_tick = 1'b0;
        tick(10);
    endtask

    task automatic test_auto_repeat();
        int s;
        btn_dn = 1'b1;
        s = cyc + LAT;
        push_exp(s, K_EN, 1'b0, 4'h0);
`ifdef COUNTER_CMD_AUTO_REPEAT_EN
        for (int k = 8; k <= 28; k += 4) push_exp(s + k, K_EN, 1'b0, 4'h0);
`endif
        tick(LAT + 24);                // debounced release lands at offset 30
        btn_dn = 1'b0;
        tick(25);
    endtask

    task automatic test_reset_in_hold();
        btn_dn = 1'b1;
        push_exp(cyc + LAT, K_EN, 1'b0, 4'h0);
        tick(10);
        reset = 1'b1;
        #1;
        checks += 2;
        if (en_a !== 1'b0) begin errors++; $display("FAIL rst_hold_en: got %b, required 0", en_a); end
        if (up_a !== 1'b1) begin errors++; $display("FAIL rst_hold_up: got %b, required 1", up_a); end
        tick(2);
        reset = 1'b0;
        push_exp(cyc + LAT, K_EN, 1'b0, 4'h0);
        tick(8);
        btn_dn = 1'b0;
        tick(20);
    endtask

    task automatic test_load();
        d_in = 4'h5;
        btn_ld = 1'b1;
        push_exp(cyc + LAT, K_LD, 1'b0, 4'h5);
        tick(8);
        btn_ld = 1'b0;
        d_in = 4'h3;
        tick(20);
    endtask

    task automatic test_back_to_back();
        btn_up = 1'b1;
        push_exp(cyc + LAT, K_EN, 1'b1, 4'h0);
        tick(8);
        btn_up = 1'b0;
        tick(2);
        btn_dn = 1'b1;
        push_exp(cyc + LAT, K_EN, 1'b0, 4'h0);
        tick(8);
        btn_dn = 1'b0;
        tick(20);
        set_btns(4'b0011);             // simultaneous up and dn: no step
        tick(10);
        set_btns(4'b0000);
        tick(20);
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_bounce();
        test_priority();
        test_saturation();
        test_auto_repeat();
        test_reset_in_hold();
        test_load();
        test_back_to_back();
        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: %0d expected pulses never seen, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter_cmd_ctrl.md
COUNTER_CMD_CTRL -- requirements
Module: counter_cmd_ctrl

Interface
REQ-001 Parameters (name, default, meaning); the block SHALL provide exactly these:
- N, 4, counter data width.
- DB_CYCLES, 16, consecutive stable samples required to accept a button level.
- RPT_DELAY, 64, hold cycles before auto-repeat starts.
- RPT_PERIOD, 16, cycles between auto-repeat pulses.
- SATURATE, 1, 1 = suppress steps at counter limits; 0 = allow wrap.

REQ-002 Ports (name, direction, width, meaning); the block SHALL provide exactly these:
- clk, in, 1, clock.
- reset, in, 1, asynchronous, active-high.
- btn_up, in, 1, raw asynchronous increment button.
- btn_dn, in, 1, raw asynchronous decrement button.
- btn_ld, in, 1, raw asynchronous load button.
- btn_clr, in, 1, raw asynchronous clear button.
- d_in, in, N, preset value, quasi-static.
- max_value_tick, in, 1, counter at 2**N-1.
- min_value_tick, in, 1, counter at 0.
- en, out, 1, count-enable pulse.
- up, out, 1, direction, 1 = up.
- load, out, 1, load pulse.
- sys_clr, out, 1, synchronous-clear pulse.
- d, out, N, value to load.

REQ-003 The block SHALL use clock clk and reset reset, asynchronous, active-high.

Function
REQ-004 Each btn_* SHALL pass through a 2-flop synchronizer before any other logic.
REQ-005 Per button, the debounced level SHALL change only after the synchronized level differs from it for DB_CYCLES consecutive cycles; any mismatch-free cycle SHALL restart that button's stability count.
REQ-006 A debounced rising edge SHALL register one command; all outputs SHALL be registered.
REQ-007 Latency: a clean raw rising edge SHALL produce its output pulse DB_CYCLES+3 cycles later.
REQ-008 en, load and sys_clr SHALL each be single-cycle pulses, mutually exclusive, at most one active per cycle.
REQ-009 Priority among simultaneous debounced edges SHALL be clr > ld > up/dn.
REQ-010 Simultaneous up and dn edges SHALL produce no step.
REQ-011 Clear SHALL produce sys_clr=1 for one cycle.
REQ-012 Load SHALL produce load=1 for one cycle, with d equal to d_in captured in that same cycle.
REQ-013 An up step SHALL produce en=1 with up=1.
REQ-014 A dn step SHALL produce en=1 with up=0.
REQ-015 up SHALL retain its last value between pulses.
REQ-016 With SATURATE=1, an up step SHALL be suppressed while max_value_tick=1, and a dn step SHALL be suppressed while min_value_tick=1.
REQ-017 With SATURATE=0, the step SHALL be issued regardless of the ticks, so the counter wraps.
REQ-018 The step FSM SHALL have states IDLE, STEP, HOLD, RELEASE.
REQ-019 IDLE->STEP SHALL occur on a debounced up or dn edge; STEP SHALL issue one pulse.
REQ-020 STEP->HOLD SHALL occur while the same button is still held; STEP->RELEASE SHALL occur if it is released.
REQ-021 HOLD SHALL return to IDLE on release.
REQ-022 RELEASE SHALL return to IDLE once all debounced buttons are low; further edges SHALL be ignored until then.
REQ-023 A clr or ld edge SHALL be accepted in any state and SHALL force the FSM to RELEASE.
REQ-024 Delay and period counters SHALL be sized ceil(log2(max+1)) bits and SHALL never wrap silently.

Reset
REQ-025 On reset, en, load and sys_clr SHALL be 0, up SHALL be 1, d SHALL be 0, the FSM SHALL be IDLE, and synchronizers, debounced levels and all counters SHALL be 0.
REQ-026 Reset asserted mid-hold or mid-pulse SHALL abort within the same clock with no residual pulse.
REQ-027 A button already held at reset release SHALL register as a new edge only after debounce completes.

Configuration
REQ-028 Macro COUNTER_CMD_AUTO_REPEAT_EN:
- Defined: HOLD SHALL issue the first repeat step RPT_DELAY cycles after the STEP pulse, then one step every RPT_PERIOD cycles while held, with each repeat subject to REQ-016.
- Undefined: HOLD SHALL issue no further steps and no delay or period counter logic SHALL be present.

Verification
REQ-029 Directed scenarios (stimulus -> required response), all with DB_CYCLES=4:
- Bounce: btn_up toggling every 2 cycles for 20 cycles, then steady high -> exactly one en=1, up=1 pulse, 7 cycles after steady high begins.
- Priority: btn_clr and btn_ld both rise in the same cycle with d_in=4'hA -> one sys_clr pulse only; no load pulse; load is ignored until all buttons are released.
- Saturation: SATURATE=1, max_value_tick=1, btn_up pressed -> no en pulse. Repeat with SATURATE=0 -> one en pulse.
- Auto-repeat, macro defined, RPT_DELAY=8, RPT_PERIOD=4, btn_dn held 30 cycles past debounce -> pulses at offsets 0, 8, 12, 16, 20, 24, 28, each with up=0. Macro undefined -> pulse at offset 0 only.
- Reset during HOLD: assert reset -> en=0 and up=1 in the same cycle; after release with btn_dn still held -> one new pulse after DB_CYCLES+3 cycles.
- Load: d_in=4'h5, btn_ld pressed -> load=1 and d=4'h5 in the same cycle, for one cycle.
